// File: rtl/seg_readback.sv
// seg_readback
// Recovers the two digits shown on a time-multiplexed, active-low, dual-digit
// seven-segment bus. The bus is asynchronous, so all nine lines are passed
// through a two-flop synchronizer. A run-length counter then waits for the
// {an_in, segs_in} value to settle before it is decoded into the digit that
// the active anode selects.
//
// Ports
//   clk      in   system clock
//   nreset   in   asynchronous active-low reset
//   segs_in  in   [6:0] active-low segments, bit6=a ... bit0=g (0 = lit)
//   an_in    in   [1:0] active-low anodes, an_in[0]=digit0, an_in[1]=digit1
//   digit0   out  [3:0] last decoded value for digit0 (4'hF = blank)
//   digit1   out  [3:0] last decoded value for digit1 (4'hF = blank)
//   valid0   out  digit0 holds a legal decimal value
//   valid1   out  digit1 holds a legal decimal value
//   upd      out  one-cycle pulse when a capture updates a digit
//   err      out  one-cycle pulse on an illegal pattern or both anodes active
module seg_readback #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [6:0] segs_in,
  input  logic [1:0] an_in,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       valid0,
  output logic       valid1,
  output logic       upd,
  output logic       err
);

  localparam logic [CNT_W-1:0] CntSat  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CntFire = CNT_W'(STABLE_CYCLES - 1);

  logic [8:0]       sync1_q, sync2_q, sPrev_q;
  logic [CNT_W-1:0] runCnt_q, runCnt_d;
  logic             taken_q, taken_d;
  logic [3:0]       digit0_q, digit0_d, digit1_q, digit1_d;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic             upd_q, upd_d, err_q, err_d;

  logic             capture;
  logic             changed;
  logic [1:0]       capAn;
  logic [6:0]       capSegs;
  logic             capLegal;
  logic             capBlank;
  logic [3:0]       capValue;

  // Inverse of the digit-to-segment mapping; returns {legal, value}.
  function automatic logic [4:0] decodeSegs(input logic [6:0] p);
    case (p)
      7'b0000001: decodeSegs = {1'b1, 4'd0};
      7'b1001111: decodeSegs = {1'b1, 4'd1};
      7'b0010010: decodeSegs = {1'b1, 4'd2};
      7'b0000110: decodeSegs = {1'b1, 4'd3};
      7'b1001100: decodeSegs = {1'b1, 4'd4};
      7'b0100100: decodeSegs = {1'b1, 4'd5};
      7'b0100000: decodeSegs = {1'b1, 4'd6};
      7'b0001111: decodeSegs = {1'b1, 4'd7};
      7'b0000000: decodeSegs = {1'b1, 4'd8};
      7'b0001100: decodeSegs = {1'b1, 4'd9};
      default:    decodeSegs = {1'b0, 4'd0};
    endcase
  endfunction

  assign changed  = (sync2_q != sPrev_q);
  assign capAn    = sync2_q[8:7];
  assign capSegs  = sync2_q[6:0];
  assign capBlank = (capSegs == 7'b1111111);
  assign {capLegal, capValue} = decodeSegs(capSegs);

  // The counter value is checked one short of the target because the edge
  // that fires is itself the final stable cycle of the window.
  assign capture = (runCnt_q == CntFire) && !changed && !taken_q;

  // Next-state: run-length tracking plus the capture decode.
  always_comb begin
    runCnt_d = runCnt_q;
    taken_d  = taken_q;
    digit0_d = digit0_q;
    digit1_d = digit1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;

    if (changed) begin
      runCnt_d = CNT_W'(1);
      taken_d  = 1'b0;
    end else if (runCnt_q != CntSat) begin
      runCnt_d = runCnt_q + CNT_W'(1);
    end

    if (capture) begin
      taken_d = 1'b1;
      case (capAn)
        2'b10: begin
          upd_d = 1'b1;
          if (capLegal) begin
            digit0_d = capValue;
            valid0_d = 1'b1;
          end else if (capBlank) begin
            digit0_d = 4'hF;
            valid0_d = 1'b0;
          end else begin
            valid0_d = 1'b0;
            err_d    = 1'b1;
          end
        end
        2'b01: begin
          upd_d = 1'b1;
          if (capLegal) begin
            digit1_d = capValue;
            valid1_d = 1'b1;
          end else if (capBlank) begin
            digit1_d = 4'hF;
            valid1_d = 1'b0;
          end else begin
            valid1_d = 1'b0;
            err_d    = 1'b1;
          end
        end
        // Both anodes driven at once can never be a legal display state.
        2'b00:   err_d = 1'b1;
        // Blanking gap between multiplex slots.
        default: ;
      endcase
    end
  end

  // State registers; the synchronizer idles at all-ones (nothing lit).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q  <= 9'h1FF;
      sync2_q  <= 9'h1FF;
      sPrev_q  <= 9'h1FF;
      runCnt_q <= '0;
      taken_q  <= 1'b0;
      digit0_q <= 4'h0;
      digit1_q <= 4'h0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= {an_in, segs_in};
      sync2_q  <= sync1_q;
      sPrev_q  <= sync2_q;
      runCnt_q <= runCnt_d;
      taken_q  <= taken_d;
      digit0_q <= digit0_d;
      digit1_q <= digit1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign digit0 = digit0_q;
  assign digit1 = digit1_q;
  assign valid0 = valid0_q;
  assign valid1 = valid1_q;
  assign upd    = upd_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seg_readback.sv
// tb_seg_readback
// Self-checking bench for seg_readback. A behavioural model tracks how many
// consecutive clock edges have sampled the same bus value and, once that run
// reaches the settle length, schedules the decoded result to appear two edges
// later (the synchronizer depth). Table-driven windows, hand sequences for
// reset behaviour, and a random phase all run against that model.
module tb_seg_readback;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic [6:0] segs_in = 7'b1111111;
  logic [1:0] an_in = 2'b11;
  logic [3:0] digit0, digit1;
  logic       valid0, valid1, upd, err;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [8:0] lastVal;
  int         runLen;
  logic       pend1V, pend2V;
  logic [8:0] pend1Val, pend2Val;
  logic [3:0] eD0, eD1;
  logic       eV0, eV1, eUpd, eErr;

  // Pulses observed from the DUT, used by the windowed checks.
  int updSeen, errSeen, lastUpdEdge, edgeNum;

  logic [6:0] segTab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0001100};

  typedef struct {
    logic [1:0] an;
    logic [6:0] segs;
    int         hold;
    logic [3:0] d0;
    logic       v0;
    logic [3:0] d1;
    logic       v1;
    int         updN;
    int         errN;
  } vec_t;

  vec_t vecs [12];

  seg_readback #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk    (clk),
    .nreset (nreset),
    .segs_in(segs_in),
    .an_in  (an_in),
    .digit0 (digit0),
    .digit1 (digit1),
    .valid0 (valid0),
    .valid1 (valid1),
    .upd    (upd),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    lastVal = 9'h1FF;
    // The two synchronizer stages already hold the idle value after reset.
    runLen  = 2;
    pend1V  = 1'b0;
    pend2V  = 1'b0;
    pend1Val = 9'h1FF;
    pend2Val = 9'h1FF;
    eD0 = 4'h0; eD1 = 4'h0; eV0 = 1'b0; eV1 = 1'b0; eUpd = 1'b0; eErr = 1'b0;
  endtask

  task automatic modelApply(input logic [8:0] v);
    logic [1:0] a;
    logic [6:0] s;
    int         found;
    a = v[8:7];
    s = v[6:0];
    found = -1;
    for (int i = 0; i < 10; i++) if (segTab[i] == s) found = i;
    if (a == 2'b00) begin
      eErr = 1'b1;
    end else if (a != 2'b11) begin
      eUpd = 1'b1;
      if (found >= 0) begin
        if (a == 2'b10) begin eD0 = 4'(found); eV0 = 1'b1; end
        else            begin eD1 = 4'(found); eV1 = 1'b1; end
      end else if (s == 7'b1111111) begin
        if (a == 2'b10) begin eD0 = 4'hF; eV0 = 1'b0; end
        else            begin eD1 = 4'hF; eV1 = 1'b0; end
      end else begin
        eErr = 1'b1;
        if (a == 2'b10) eV0 = 1'b0;
        else            eV1 = 1'b0;
      end
    end
  endtask

  task automatic modelEdge();
    logic [8:0] sampled;
    sampled = {an_in, segs_in};
    eUpd = 1'b0;
    eErr = 1'b0;
    if (pend2V) modelApply(pend2Val);
    pend2V   = pend1V;
    pend2Val = pend1Val;
    if (sampled == lastVal) begin
      if (runLen < 1000) runLen++;
    end else begin
      runLen = 1;
    end
    lastVal  = sampled;
    pend1V   = (runLen == STABLE);
    pend1Val = sampled;
  endtask

  task automatic checkOutput(input string name);
    vectors++;
    if (digit0 !== eD0 || digit1 !== eD1 || valid0 !== eV0 || valid1 !== eV1 ||
        upd !== eUpd || err !== eErr) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t actual d0=%h v0=%b d1=%h v1=%b upd=%b err=%b required d0=%h v0=%b d1=%h v1=%b upd=%b err=%b",
               name, $time, digit0, valid0, digit1, valid1, upd, err,
               eD0, eV0, eD1, eV1, eUpd, eErr);
    end
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // One clock edge: advance the model, then compare on the falling edge.
  task automatic step(input string name);
    @(posedge clk);
    if (nreset) modelEdge();
    else        modelReset();
    @(negedge clk);
    edgeNum++;
    if (upd === 1'b1) begin updSeen++; lastUpdEdge = edgeNum; end
    if (err === 1'b1) errSeen++;
    checkOutput(name);
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [6:0] s, input int n,
                               input string name);
    an_in   = a;
    segs_in = s;
    for (int i = 0; i < n; i++) step(name);
  endtask

  task automatic clearCounts();
    updSeen = 0; errSeen = 0; lastUpdEdge = 0; edgeNum = 0;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 7'b0000110, 12, 4'd3, 1'b1, 4'd0, 1'b0, 1, 0};
    vecs[1]  = '{2'b11, 7'b1111111,  3, 4'd3, 1'b1, 4'd0, 1'b0, 0, 0};
    vecs[2]  = '{2'b01, 7'b0001100, 12, 4'd3, 1'b1, 4'd9, 1'b1, 1, 0};
    vecs[3]  = '{2'b11, 7'b1111111,  3, 4'd3, 1'b1, 4'd9, 1'b1, 0, 0};
    vecs[4]  = '{2'b10, 7'b0100100, 12, 4'd5, 1'b1, 4'd9, 1'b1, 1, 0};
    vecs[5]  = '{2'b10, 7'b0000000,  2, 4'd5, 1'b1, 4'd9, 1'b1, 0, 0};
    vecs[6]  = '{2'b10, 7'b0100100, 12, 4'd5, 1'b1, 4'd9, 1'b1, 1, 0};
    vecs[7]  = '{2'b01, 7'b1010101, 12, 4'd5, 1'b1, 4'd9, 1'b0, 1, 1};
    vecs[8]  = '{2'b01, 7'b1111111, 12, 4'd5, 1'b1, 4'hF, 1'b0, 1, 0};
    vecs[9]  = '{2'b00, 7'b0000001, 12, 4'd5, 1'b1, 4'hF, 1'b0, 0, 1};
    vecs[10] = '{2'b10, 7'b0001111, 12, 4'd7, 1'b1, 4'hF, 1'b0, 1, 0};
    vecs[11] = '{2'b10, 7'b0000001, 12, 4'd0, 1'b1, 4'hF, 1'b0, 1, 0};

    // Reset with a digit0=2 pattern already on the bus.
    modelReset();
    clearCounts();
    an_in   = 2'b10;
    segs_in = 7'b0010010;
    #1 nreset = 1'b0;
    for (int i = 0; i < 3; i++) step("resetHold");
    nreset = 1'b1;
    clearCounts();
    for (int i = 0; i < 9; i++) step("resetRelease");
    checkVal("resetUpdEdge", lastUpdEdge, 6);
    checkVal("resetUpdCount", updSeen, 1);
    checkVal("resetDigit0", int'(digit0), 2);
    checkVal("resetValid0", int'(valid0), 1);

    // Table-driven windows: multiplex sweep, glitch, illegal, blank, both anodes.
    for (int v = 0; v < 12; v++) begin
      clearCounts();
      applyStimulus(vecs[v].an, vecs[v].segs, vecs[v].hold, "tableCycle");
      checkVal($sformatf("vec%0d_upd", v), updSeen, vecs[v].updN);
      checkVal($sformatf("vec%0d_err", v), errSeen, vecs[v].errN);
      vectors++;
      if (digit0 !== vecs[v].d0 || valid0 !== vecs[v].v0 ||
          digit1 !== vecs[v].d1 || valid1 !== vecs[v].v1) begin
        miscompares++;
        $display("[TB] FAIL vec%0d_state actual d0=%h v0=%b d1=%h v1=%b required d0=%h v0=%b d1=%h v1=%b",
                 v, digit0, valid0, digit1, valid1,
                 vecs[v].d0, vecs[v].v0, vecs[v].d1, vecs[v].v1);
      end
    end

    // Reset arriving part-way through a digit0=7 window.
    clearCounts();
    applyStimulus(2'b10, 7'b0001111, 3, "midWindow");
    #2 nreset = 1'b0;
    #1 modelReset();
    checkOutput("midResetImmediate");
    checkVal("midResetDigit0", int'(digit0), 0);
    checkVal("midResetValid0", int'(valid0), 0);
    for (int i = 0; i < 2; i++) step("midResetHold");
    nreset = 1'b1;
    clearCounts();
    for (int i = 0; i < 9; i++) step("midResetRelease");
    checkVal("midResetUpdEdge", lastUpdEdge, 6);
    checkVal("midResetUpdCount", updSeen, 1);
    checkVal("midResetDigit0After", int'(digit0), 7);

    // Random windows with random hold lengths, including sub-threshold glitches.
    for (int w = 0; w < 120; w++) begin
      logic [1:0] a;
      logic [6:0] s;
      int         pick;
      pick = int'($urandom_range(0, 9));
      a = (pick < 4) ? 2'b10 : (pick < 8) ? 2'b01 : (pick == 8) ? 2'b11 : 2'b00;
      pick = int'($urandom_range(0, 9));
      if (pick < 7)       s = segTab[$urandom_range(0, 9)];
      else if (pick == 7) s = 7'b1111111;
      else                s = 7'($urandom);
      applyStimulus(a, s, int'($urandom_range(1, 10)), "randomCycle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
